// File: rtl/ts_bus_master.sv
// Turbosound-FM bus initiator: queued write/read/select commands become BDIR/BC/DO phases.
// Optional `TS_BUS_RD_FIFO_EN adds RD_READY and a 2-entry read-result FIFO.
module ts_bus_master #(
  parameter int unsigned HOLD_CYC   = 4,
  parameter int unsigned GAP_CYC    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [1:0] CMD_OP,
  input  logic [7:0] CMD_ADDR,
  input  logic [7:0] CMD_DATA,
`ifdef TS_BUS_RD_FIFO_EN
  input  logic       RD_READY,
`endif
  output logic       RD_VALID,
  output logic [7:0] RD_DATA,
  output logic       BUSY,
  output logic       BDIR,
  output logic       BC,
  output logic [7:0] DO,
  input  logic [7:0] DI
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam logic [3:0]  HOLD_LD = 4'(HOLD_CYC - 1);
  localparam logic [3:0]  GAP_LD  = 4'(GAP_CYC - 1);

  typedef enum logic [1:0] {OP_WR = 2'b00, OP_RD = 2'b01, OP_SEL = 2'b10, OP_RSV = 2'b11} op_e;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_GAP1, S_WR, S_RD, S_GAP2} state_e;

  typedef struct packed {
    op_e        op;
    logic [7:0] addr;
    logic [7:0] data;
  } cmd_t;

  cmd_t          mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, empty, push, pop, rd_stall;
  cmd_t          head;

  state_e        state;
  logic [3:0]    cnt;
  op_e           cmd_op;
  logic [7:0]    cmd_data;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign CMD_READY = !full;
  assign push      = CMD_VALID && !full;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign pop       = (state == S_IDLE) && !empty && !rd_stall;
  assign BUSY      = !empty || (state != S_IDLE);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= cmd_t'{op: op_e'(CMD_OP), addr: CMD_ADDR, data: CMD_DATA};
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

`ifdef TS_BUS_RD_FIFO_EN
  logic [7:0] res_mem [2];
  logic [1:0] res_wp, res_rp;
  logic       res_push, res_pop, res_full;

  assign res_push = (state == S_RD) && (cnt == '0);
  assign res_full = (res_wp[1] != res_rp[1]) && (res_wp[0] == res_rp[0]);
  assign RD_VALID = (res_wp != res_rp);
  assign res_pop  = RD_VALID && RD_READY;
  assign RD_DATA  = res_mem[res_rp[0]];
  // Only a read needs result space; writes and selects keep flowing while full.
  assign rd_stall = res_full && (head.op == OP_RD);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      res_wp  <= '0;
      res_rp  <= '0;
      res_mem <= '{default: '0};
    end else begin
      if (res_push) begin
        res_mem[res_wp[0]] <= DI;
        res_wp             <= res_wp + 1'b1;
      end
      if (res_pop)
        res_rp <= res_rp + 1'b1;
    end
  end
`else
  assign rd_stall = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= S_IDLE;
      cnt      <= '0;
      cmd_op   <= OP_WR;
      cmd_data <= '0;
      BDIR     <= 1'b0;
      BC       <= 1'b0;
      DO       <= '0;
`ifndef TS_BUS_RD_FIFO_EN
      RD_VALID <= 1'b0;
      RD_DATA  <= '0;
`endif
    end else begin
`ifndef TS_BUS_RD_FIFO_EN
      RD_VALID <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          if (pop) begin
            cmd_op   <= head.op;
            cmd_data <= head.data;
            // Reserved ops are consumed here without touching the bus.
            if (head.op != OP_RSV) begin
              state <= S_ADDR;
              cnt   <= HOLD_LD;
              BDIR  <= 1'b1;
              BC    <= 1'b1;
              DO    <= (head.op == OP_SEL) ? {5'b11111, head.data[2:0]} : head.addr;
            end
          end
        end
        S_ADDR: begin
          if (cnt == '0) begin
            state <= S_GAP1;
            cnt   <= GAP_LD;
            BDIR  <= 1'b0;
            BC    <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_GAP1: begin
          if (cnt == '0) begin
            case (cmd_op)
              OP_WR: begin
                state <= S_WR;
                cnt   <= HOLD_LD;
                BDIR  <= 1'b1;
                DO    <= cmd_data;
              end
              OP_RD: begin
                state <= S_RD;
                cnt   <= HOLD_LD;
                BC    <= 1'b1;
                DO    <= '0;
              end
              default: begin
                state <= S_IDLE;
                cnt   <= '0;
              end
            endcase
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_WR: begin
          if (cnt == '0) begin
            state <= S_GAP2;
            cnt   <= GAP_LD;
            BDIR  <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RD: begin
          if (cnt == '0) begin
            state <= S_GAP2;
            cnt   <= GAP_LD;
            BC    <= 1'b0;
`ifndef TS_BUS_RD_FIFO_EN
            RD_DATA  <= DI;
            RD_VALID <= 1'b1;
`endif
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_GAP2: begin
          if (cnt == '0) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ts_bus_master.sv
// Self-checking bench for ts_bus_master (default build): vector table, exact write timing,
// back-pressure ordering and mid-phase reset, with a bus-phase scoreboard.
module tb_ts_bus_master;

  localparam int HOLD = 4;
  localparam int GAP  = 2;

  logic       CLK = 1'b0;
  logic       RESET, CMD_VALID, CMD_READY;
  logic [1:0] CMD_OP;
  logic [7:0] CMD_ADDR, CMD_DATA;
  logic       RD_VALID, BUSY, BDIR, BC;
  logic [7:0] RD_DATA, DO, DI;

  ts_bus_master #(.HOLD_CYC(HOLD), .GAP_CYC(GAP), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RESET(RESET), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA),
    .RD_VALID(RD_VALID), .RD_DATA(RD_DATA), .BUSY(BUSY),
    .BDIR(BDIR), .BC(BC), .DO(DO), .DI(DI)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic       bdir;
    logic       bc;
    logic [7:0] d;
  } ph_t;

  ph_t        exp_q[$];
  logic [7:0] rd_q[$];
  bit         mon_en = 1'b1;

  // Phase scoreboard: every BDIR/BC burst is checked for value, stability, length and gap.
  initial begin : monitor
    logic [1:0] prev_bb, last_bb;
    ph_t        cur, e;
    int         run_len, gap_len;
    logic       prev_rdv;
    prev_bb = '0; last_bb = '0; cur = '0; run_len = 0; gap_len = 100; prev_rdv = 1'b0;
    forever begin
      @(negedge CLK);
      if (RESET || !mon_en) begin
        prev_bb = '0; run_len = 0; gap_len = 100; prev_rdv = 1'b0;
      end else begin
        if ({BDIR, BC} != 2'b00) begin
          if (prev_bb == 2'b00) begin
            chk("gap_before_phase", 32'(gap_len >= GAP), 32'd1);
            cur     = {BDIR, BC, DO};
            run_len = 1;
          end else begin
            chk("phase_stable", 32'({BDIR, BC, DO}), 32'(cur));
            run_len++;
          end
          gap_len = 0;
        end else begin
          if (prev_bb != 2'b00) begin
            last_bb = prev_bb;
            chk("phase_len", 32'(run_len), 32'(HOLD));
            chk("phase_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              chk("phase_value", 32'(cur), 32'(e));
            end
          end
          gap_len++;
        end
        if (RD_VALID) begin
          chk("rdv_first_gap2", 32'(gap_len == 1 && last_bb == 2'b01), 32'd1);
          chk("rdv_pulse", 32'(prev_rdv), 32'd0);
          chk("rd_expected", 32'(rd_q.size() != 0), 32'd1);
          if (rd_q.size() != 0) chk("rd_data", 32'(RD_DATA), 32'(rd_q.pop_front()));
        end
        prev_rdv = RD_VALID;
        prev_bb  = {BDIR, BC};
      end
    end
  end

  task automatic push_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                          output int unsigned waited);
    waited = 0;
    CMD_OP = op; CMD_ADDR = a; CMD_DATA = d; CMD_VALID = 1'b1;
    while (!CMD_READY && waited < 100) begin
      @(posedge CLK); #1;
      waited++;
    end
    chk("push_ready", 32'(CMD_READY), 32'd1);
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned limit);
    int unsigned t = 0;
    while (BUSY && t < limit) begin
      @(posedge CLK); #1;
      t++;
    end
    chk("idle_timeout", 32'(BUSY), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] di;
    int         nph;
    ph_t        p0;
    ph_t        p1;
    bit         has_rd;
    logic [7:0] rd;
  } vec_t;

  vec_t vt[7];

  initial begin
    int unsigned w;
    logic [1:0]  exp_bb;
    logic [7:0]  exp_do;
    logic        exp_busy;
    bit          found, act;

    vt[0] = '{op: 2'b00, addr: 8'h07, data: 8'h38, di: 8'h00, nph: 2,
              p0: {2'b11, 8'h07}, p1: {2'b10, 8'h38}, has_rd: 1'b0, rd: 8'h00};
    vt[1] = '{op: 2'b01, addr: 8'h0E, data: 8'h00, di: 8'hA5, nph: 2,
              p0: {2'b11, 8'h0E}, p1: {2'b01, 8'h00}, has_rd: 1'b1, rd: 8'hA5};
    vt[2] = '{op: 2'b10, addr: 8'h33, data: 8'h06, di: 8'h00, nph: 1,
              p0: {2'b11, 8'hFE}, p1: '0, has_rd: 1'b0, rd: 8'h00};
    vt[3] = '{op: 2'b11, addr: 8'h55, data: 8'hAA, di: 8'h00, nph: 0,
              p0: '0, p1: '0, has_rd: 1'b0, rd: 8'h00};
    vt[4] = '{op: 2'b01, addr: 8'h0B, data: 8'h77, di: 8'h3C, nph: 2,
              p0: {2'b11, 8'h0B}, p1: {2'b01, 8'h00}, has_rd: 1'b1, rd: 8'h3C};
    vt[5] = '{op: 2'b00, addr: 8'hFF, data: 8'h00, di: 8'h00, nph: 2,
              p0: {2'b11, 8'hFF}, p1: {2'b10, 8'h00}, has_rd: 1'b0, rd: 8'h00};
    vt[6] = '{op: 2'b10, addr: 8'h01, data: 8'h08, di: 8'h00, nph: 1,
              p0: {2'b11, 8'hF8}, p1: '0, has_rd: 1'b0, rd: 8'h00};

    RESET = 1'b1; CMD_VALID = 1'b0; CMD_OP = '0; CMD_ADDR = '0; CMD_DATA = '0; DI = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_bdir", 32'(BDIR), 32'd0);
    chk("rst_bc", 32'(BC), 32'd0);
    chk("rst_do", 32'(DO), 32'd0);
    chk("rst_rd_valid", 32'(RD_VALID), 32'd0);
    chk("rst_rd_data", 32'(RD_DATA), 32'd0);
    chk("rst_cmd_ready", 32'(CMD_READY), 32'd1);
    chk("rst_busy", 32'(BUSY), 32'd0);
    RESET = 1'b0;
    @(posedge CLK); #1;

    // Exact cycle-by-cycle write: accept at E0, pop at E1, idle after E13.
    exp_q.push_back({2'b11, 8'h07});
    exp_q.push_back({2'b10, 8'h38});
    CMD_OP = 2'b00; CMD_ADDR = 8'h07; CMD_DATA = 8'h38; CMD_VALID = 1'b1;
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
    @(negedge CLK);
    chk("wr_e0", 32'({BUSY, BDIR, BC}), 32'({1'b1, 2'b00}));
    for (int k = 1; k <= 13; k++) begin
      @(negedge CLK);
      exp_bb   = (k <= 4) ? 2'b11 : (k >= 7 && k <= 10) ? 2'b10 : 2'b00;
      exp_do   = (k <= 6) ? 8'h07 : 8'h38;
      exp_busy = (k < 13);
      chk("wr_seq", 32'({BUSY, BDIR, BC, DO}), 32'({exp_busy, exp_bb, exp_do}));
    end
    @(posedge CLK); #1;
    wait_idle(50);

    for (int i = 0; i < 7; i++) begin
      DI = vt[i].di;
      if (vt[i].nph > 0) exp_q.push_back(vt[i].p0);
      if (vt[i].nph > 1) exp_q.push_back(vt[i].p1);
      if (vt[i].has_rd) rd_q.push_back(vt[i].rd);
      push_cmd(vt[i].op, vt[i].addr, vt[i].data, w);
      wait_idle(100);
      chk("vec_phases_done", 32'(exp_q.size()), 32'd0);
      chk("vec_reads_done", 32'(rd_q.size()), 32'd0);
    end
    chk("rd_data_hold", 32'(RD_DATA), 32'h3C);

    // Back-pressure: five back-to-back writes fill the FIFO behind the one in flight.
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({2'b11, 8'(8'h10 + i)});
      exp_q.push_back({2'b10, 8'(8'h20 + i)});
    end
    exp_q.push_back({2'b11, 8'h30});
    exp_q.push_back({2'b10, 8'h31});
    for (int i = 0; i < 5; i++) begin
      push_cmd(2'b00, 8'(8'h10 + i), 8'(8'h20 + i), w);
      chk("bp_no_wait", 32'(w), 32'd0);
    end
    chk("bp_full_ready", 32'(CMD_READY), 32'd0);
    chk("bp_busy", 32'(BUSY), 32'd1);
    push_cmd(2'b11, 8'h99, 8'h99, w);
    push_cmd(2'b00, 8'h30, 8'h31, w);
    wait_idle(400);
    chk("bp_phases_done", 32'(exp_q.size()), 32'd0);
    chk("bp_ready_after", 32'(CMD_READY), 32'd1);

    // Reset during the WR phase of the second of three queued writes.
    mon_en = 1'b0;
    exp_q.delete();
    rd_q.delete();
    push_cmd(2'b00, 8'h51, 8'h41, w);
    push_cmd(2'b00, 8'h52, 8'h42, w);
    push_cmd(2'b00, 8'h53, 8'h43, w);
    found = 1'b0;
    for (int t = 0; t < 200 && !found; t++) begin
      if (BDIR && !BC && DO == 8'h42) found = 1'b1;
      else begin
        @(posedge CLK); #1;
      end
    end
    chk("rst_found_wr2", 32'(found), 32'd1);
    RESET = 1'b1;
    @(posedge CLK); #1;
    chk("mid_rst_bdir_bc", 32'({BDIR, BC}), 32'd0);
    chk("mid_rst_busy", 32'(BUSY), 32'd0);
    chk("mid_rst_ready", 32'(CMD_READY), 32'd1);
    chk("mid_rst_do", 32'(DO), 32'd0);
    RESET = 1'b0;
    act = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge CLK);
      if (BDIR || BC || RD_VALID || BUSY) act = 1'b1;
    end
    chk("mid_rst_quiet", 32'(act), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
